circuit1_bist_sequencer: RTL and testbench

//  Hardware self-test sequencer for the 4-input combinational Circuit1 (F = f(A,B,C,D)).
//  On Start, drives all 16 input combinations in ascending order, waits a settle interval per

---
 rtl/circuit1_bist_sequencer_pkg.sv | 26 ++
 rtl/circuit1_bist_sequencer_if.sv | 38 +++
 rtl/circuit1_bist_sequencer_settle_counter.sv | 27 ++
 rtl/circuit1_bist_sequencer.sv | 120 ++++++++++++
 tb/tb_circuit1_bist_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/circuit1_bist_sequencer_pkg.sv
// Shared constants and state encodings for the Circuit1 BIST sequencer.
package circuit1_bist_sequencer_pkg;

  localparam int N_INPUTS  = 4;
  localparam int N_VECTORS = 16;
  localparam int VEC_W     = 4;
  localparam int ERRCNT_W  = 5;
  localparam int SETTLE_W  = 4;

  typedef logic [1:0]       state_t;
  typedef logic [VEC_W-1:0] vec_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_APPLY  = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  localparam vec_t                LAST_VEC = vec_t'(N_VECTORS - 1);
  localparam logic [ERRCNT_W-1:0] ERR_MAX  = ERRCNT_W'(N_VECTORS);

  // The counter expires when it reaches zero, so it is loaded one short of the hold time.
  function automatic logic [SETTLE_W-1:0] settle_load(input int cycles);
    return SETTLE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/circuit1_bist_sequencer_if.sv
// Bus between the lab top level (master) and the BIST sequencer (slave); error-log
// signals exist only when BIST_ERRLOG_EN is defined.
interface circuit1_bist_sequencer_if;
  import circuit1_bist_sequencer_pkg::*;

  logic                start;
  logic                abort;
  logic                f;
  logic                a;
  logic                b;
  logic                c;
  logic                d;
  logic                busy;
  logic                done;
  logic                fail;
  logic [ERRCNT_W-1:0] err_cnt;
`ifdef BIST_ERRLOG_EN
  logic [VEC_W-1:0]    first_err_vec;
  logic                first_err_vld;
`endif

  modport master (
`ifdef BIST_ERRLOG_EN
    input  first_err_vec, first_err_vld,
`endif
    output start, abort, f,
    input  a, b, c, d, busy, done, fail, err_cnt
  );

  modport slave (
`ifdef BIST_ERRLOG_EN
    output first_err_vec, first_err_vld,
`endif
    input  start, abort, f,
    output a, b, c, d, busy, done, fail, err_cnt
  );

endinterface

// File: rtl/circuit1_bist_sequencer_settle_counter.sv
// Per-vector settle timer: loads on request, counts down to zero, expire is the terminal count.
module circuit1_bist_sequencer_settle_counter
  import circuit1_bist_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= settle_load(SETTLE_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/circuit1_bist_sequencer.sv
// Sweeps all 16 Circuit1 input vectors, compares F against EXPECTED and reports pass/fail.
// Optional first-mismatch log enabled by defining BIST_ERRLOG_EN.
module circuit1_bist_sequencer
  import circuit1_bist_sequencer_pkg::*;
#(
  parameter logic [15:0] EXPECTED      = 16'h0000,
  parameter int          SETTLE_CYCLES = 2
) (
  input logic                      clk,
  input logic                      rst,
  circuit1_bist_sequencer_if.slave bus
);

  state_t              state;
  vec_t                vec;
  logic                fail_r;
  logic [ERRCNT_W-1:0] err_cnt_r;
  logic                go;
  logic                active;
  logic                abort_now;
  logic                sampling;
  logic                mismatch;
  logic                expire;

  assign active    = (state == ST_APPLY) || (state == ST_SAMPLE);
  assign go        = bus.start && !active;
  assign abort_now = bus.abort && active;
  assign sampling  = (state == ST_SAMPLE);
  assign mismatch  = sampling && (bus.f != EXPECTED[vec]);

  circuit1_bist_sequencer_settle_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load   (go || sampling),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      vec   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            state <= ST_APPLY;
            vec   <= '0;
          end
        end
        ST_APPLY: begin
          if (abort_now) begin
            state <= ST_IDLE;
            vec   <= '0;
          end else if (expire) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (abort_now) begin
            state <= ST_IDLE;
            vec   <= '0;
          end else if (vec == LAST_VEC) begin
            state <= ST_DONE;
          end else begin
            state <= ST_APPLY;
            vec   <= vec + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          vec   <= '0;
        end
      endcase
    end
  end

  // A mismatch on the aborting SAMPLE edge is still counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_r    <= 1'b0;
      err_cnt_r <= '0;
    end else if (go) begin
      fail_r    <= 1'b0;
      err_cnt_r <= '0;
    end else if (mismatch) begin
      fail_r <= 1'b1;
      if (err_cnt_r != ERR_MAX) begin
        err_cnt_r <= err_cnt_r + 1'b1;
      end
    end
  end

`ifdef BIST_ERRLOG_EN
  vec_t first_vec_r;
  logic first_vld_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_vec_r <= '0;
      first_vld_r <= 1'b0;
    end else if (go) begin
      first_vec_r <= '0;
      first_vld_r <= 1'b0;
    end else if (mismatch && !first_vld_r) begin
      first_vec_r <= vec;
      first_vld_r <= 1'b1;
    end
  end

  assign bus.first_err_vec = first_vec_r;
  assign bus.first_err_vld = first_vld_r;
`endif

  assign {bus.a, bus.b, bus.c, bus.d} = vec;
  assign bus.busy    = active;
  assign bus.done    = (state == ST_DONE);
  assign bus.fail    = fail_r;
  assign bus.err_cnt = err_cnt_r;

endmodule

// File: tb/tb_circuit1_bist_sequencer.sv
// Self-checking bench for circuit1_bist_sequencer: sweep table plus reset, abort and settle-length cases.
module tb_circuit1_bist_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  circuit1_bist_sequencer_if bus0 ();
  circuit1_bist_sequencer_if bus1 ();
  circuit1_bist_sequencer_if bus2 ();
  circuit1_bist_sequencer_if bus3 ();

  logic [15:0] tt   = 16'hA5C3;
  logic [15:0] mask = 16'h0000;
  logic        ms   = 1'b0;
  logic [3:0]  v0, v1, v2, v3;

  assign v0 = {bus0.a, bus0.b, bus0.c, bus0.d};
  assign v1 = {bus1.a, bus1.b, bus1.c, bus1.d};
  assign v2 = {bus2.a, bus2.b, bus2.c, bus2.d};
  assign v3 = {bus3.a, bus3.b, bus3.c, bus3.d};

  // Circuit1 stubs: good table with optional per-vector inversion, or F tied low.
  assign bus0.f = tt[v0] ^ mask[v0];
  assign bus1.f = 1'b0;
  assign bus2.f = tt[v2];
  assign bus3.f = tt[v3];
  assign bus1.start = ms;
  assign bus2.start = ms;
  assign bus3.start = ms;
  assign bus1.abort = 1'b0;
  assign bus2.abort = 1'b0;
  assign bus3.abort = 1'b0;

  circuit1_bist_sequencer #(.EXPECTED(16'hA5C3), .SETTLE_CYCLES(2))  u0 (.clk(clk), .rst(rst), .bus(bus0));
  circuit1_bist_sequencer #(.EXPECTED(16'hFFFF), .SETTLE_CYCLES(2))  u1 (.clk(clk), .rst(rst), .bus(bus1));
  circuit1_bist_sequencer #(.EXPECTED(16'hA5C3), .SETTLE_CYCLES(1))  u2 (.clk(clk), .rst(rst), .bus(bus2));
  circuit1_bist_sequencer #(.EXPECTED(16'hA5C3), .SETTLE_CYCLES(15)) u3 (.clk(clk), .rst(rst), .bus(bus3));

  int total = 0;
  int bad   = 0;

  typedef struct {
    int done_edge;
    int err;
    int fail;
    int first;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] fmask;
    int          err;
    int          fail;
    int          first;
    int          start_at;
    int          abort_at;
  } row_t;

  exp_t sb[$];
  row_t tbl[7];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input row_t r);
    exp_t e;
    exp_t got;
    int   edges;
    bit   aborted;
    mask        = r.fmask;
    e.done_edge = (r.abort_at >= 0) ? -1 : 48;
    e.err       = r.err;
    e.fail      = r.fail;
    e.first     = r.first;
    sb.push_back(e);
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    edges   = 0;
    aborted = 0;
    chk({r.name, " done_clr"}, bus0.done, 0);
    chk({r.name, " err_clr"}, bus0.err_cnt, 0);
    chk({r.name, " fail_clr"}, bus0.fail, 0);
    while (!bus0.done && !aborted && edges < 200) begin
      chk({r.name, " vec"}, v0, edges / 3);
      chk({r.name, " busy"}, bus0.busy, 1);
      if (edges == r.start_at) bus0.start = 1'b1;
      if (edges == r.abort_at) begin
        bus0.abort = 1'b1;
        bus0.start = 1'b1;
      end
      tick();
      edges++;
      if (bus0.abort) aborted = 1;
      bus0.start = 1'b0;
      bus0.abort = 1'b0;
    end
    got = sb.pop_front();
    if (got.done_edge < 0) begin
      chk({r.name, " abort_busy"}, bus0.busy, 0);
      chk({r.name, " abort_done"}, bus0.done, 0);
      chk({r.name, " abort_vec"}, v0, 0);
    end else begin
      chk({r.name, " done_edge"}, edges, got.done_edge);
      chk({r.name, " done_busy"}, bus0.busy, 0);
      chk({r.name, " done_vec"}, v0, 15);
    end
    chk({r.name, " err_cnt"}, bus0.err_cnt, got.err);
    chk({r.name, " fail"}, bus0.fail, got.fail);
`ifdef BIST_ERRLOG_EN
    chk({r.name, " first_vld"}, bus0.first_err_vld, got.fail);
    chk({r.name, " first_vec"}, bus0.first_err_vec, got.first);
`endif
  endtask

  initial begin
    int d1, d2, d3, edges;
    bus0.start = 1'b0;
    bus0.abort = 1'b0;

    tbl[0] = '{"good",       16'h0000, 0,  0, 0, -1, -1};
    tbl[1] = '{"bad_v5",     16'h0020, 1,  1, 5, -1, -1};
    tbl[2] = '{"all_bad",    16'hFFFF, 16, 1, 0, -1, -1};
    tbl[3] = '{"good_again", 16'h0000, 0,  0, 0, -1, -1};
    tbl[4] = '{"start_busy", 16'h8010, 2,  1, 4, 21, -1};
    tbl[5] = '{"abort_v9",   16'h0004, 1,  1, 2, -1, 27};
    tbl[6] = '{"after_abort",16'h0000, 0,  0, 0, -1, -1};

    #1;
    chk("rst vec", v0, 0);
    chk("rst busy", bus0.busy, 0);
    chk("rst done", bus0.done, 0);
    chk("rst fail", bus0.fail, 0);
    chk("rst err", bus0.err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_sweep(tbl[i]);
      tick();
    end

    // Abort while DONE must be ignored.
    bus0.abort = 1'b1;
    tick();
    bus0.abort = 1'b0;
    chk("abort_in_done done", bus0.done, 1);
    chk("abort_in_done vec", v0, 15);

    // Asynchronous reset mid-sweep at vector 4, with one error already logged.
    mask = 16'h0002;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    repeat (12) tick();
    chk("pre_rst vec", v0, 4);
    chk("pre_rst err", bus0.err_cnt, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst vec", v0, 0);
    chk("async_rst busy", bus0.busy, 0);
    chk("async_rst done", bus0.done, 0);
    chk("async_rst fail", bus0.fail, 0);
    chk("async_rst err", bus0.err_cnt, 0);
`ifdef BIST_ERRLOG_EN
    chk("async_rst first_vld", bus0.first_err_vld, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_sweep(tbl[0]);

    // F tied low against all-ones table, plus settle lengths 1 and 15.
    ms = 1'b1;
    tick();
    ms = 1'b0;
    edges = 0;
    d1 = -1;
    d2 = -1;
    d3 = -1;
    while (edges < 300 && (d1 < 0 || d2 < 0 || d3 < 0)) begin
      tick();
      edges++;
      if (bus1.done && d1 < 0) d1 = edges;
      if (bus2.done && d2 < 0) d2 = edges;
      if (bus3.done && d3 < 0) d3 = edges;
    end
    chk("tied0 done_edge", d1, 48);
    chk("tied0 err_cnt", bus1.err_cnt, 16);
    chk("tied0 fail", bus1.fail, 1);
    chk("tied0 vec", v1, 15);
`ifdef BIST_ERRLOG_EN
    chk("tied0 first_vec", bus1.first_err_vec, 0);
    chk("tied0 first_vld", bus1.first_err_vld, 1);
`endif
    chk("settle1 done_edge", d2, 32);
    chk("settle1 err_cnt", bus2.err_cnt, 0);
    chk("settle1 fail", bus2.fail, 0);
    chk("settle15 done_edge", d3, 256);
    chk("settle15 err_cnt", bus3.err_cnt, 0);
    chk("settle15 fail", bus3.fail, 0);
    chk("settle15 vec", v3, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
